// File: rtl/int_pkg.sv
// Shared definitions for the integer op dispatch stage: op encoding,
// default widths and the default-width view of a queued request.
package int_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int TAG_W_DEF = 4;
  localparam int DEPTH_DEF = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic                 op;
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic [TAG_W_DEF-1:0] tag;
  } fifo_entry_t;

endpackage

// File: rtl/chunked_add.sv
// Combinational adder split into two halves; the low-half carry ripples into the high half.
module chunked_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  localparam int H = WIDTH / 2;

  logic [H:0]   lo;
  logic [H-1:0] hi;

  assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]};
  assign hi  = a[WIDTH-1:H] + b[WIDTH-1:H] + H'(lo[H]);
  assign sum = {hi, lo[H-1:0]};

endmodule

// File: rtl/chunked_sub.sv
// Combinational subtractor split into two halves; the low-half borrow ripples into the high half.
module chunked_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);

  localparam int H = WIDTH / 2;

  logic [H:0]   lo;
  logic [H-1:0] hi;

  assign lo   = {1'b0, a[H-1:0]} - {1'b0, b[H-1:0]};
  assign hi   = a[WIDTH-1:H] - b[WIDTH-1:H] - H'(lo[H]);
  assign diff = {hi, lo[H-1:0]};

endmodule

// File: rtl/sync_fifo.sv
// In-order FIFO with registered entry count; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/int_op_dispatch.sv
// Queues add/sub requests, evaluates the head through the chunked units and
// registers result, carry/borrow flag and tag into a valid/ready output stage.
module int_op_dispatch
  import int_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_flag,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   occupancy
);

  // Same layout as int_pkg::fifo_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           wr_entry;
  entry_t           head;
  logic             push;
  logic             load;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] head_result;
  logic             head_flag;
  logic             ext_unused;

  assign wr_entry = {in_op, in_a, in_b, in_tag};
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign load     = !empty && (!out_valid || out_ready);

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (load),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  chunked_add #(.WIDTH(WIDTH)) u_add (
    .a   (head.a),
    .b   (head.b),
    .sum (add_sum)
  );

  chunked_sub #(.WIDTH(WIDTH)) u_sub (
    .a    (head.a),
    .b    (head.b),
    .diff (sub_diff)
  );

  // The chunked units expose no carry/borrow, so the flag comes from a widened op here.
  assign add_ext    = {1'b0, head.a} + {1'b0, head.b};
  assign sub_ext    = {1'b0, head.a} - {1'b0, head.b};
  assign ext_unused = ^{add_ext[WIDTH-1:0], sub_ext[WIDTH-1:0]};

  assign head_result = (head.op == OP_SUB) ? sub_diff       : add_sum;
  assign head_flag   = (head.op == OP_SUB) ? sub_ext[WIDTH] : add_ext[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flag   <= 1'b0;
      out_tag    <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_result <= head_result;
      out_flag   <= head_flag;
      out_tag    <= head.tag;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_op_dispatch.sv
// Randomised and directed checks of int_op_dispatch against a queue-based
// transaction model (pending ops plus one held result).
module tb_int_op_dispatch;
  import int_pkg::*;

  localparam int W  = WIDTH_DEF;
  localparam int D  = DEPTH_DEF;
  localparam int TW = TAG_W_DEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_flag;
  logic [TW-1:0] out_tag;
  logic [$clog2(D):0] occupancy;

  int_op_dispatch #(.WIDTH(W), .DEPTH(D), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flag   (out_flag),
    .out_tag    (out_tag),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic          flag;
    logic [TW-1:0] tag;
  } res_t;

  res_t          pend_q[$];
  res_t          hold;
  bit            hold_v;
  logic [TW-1:0] hs_tags[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            hs_cnt   = 0;
  int            max_occ  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic fifo_entry_t mk(input logic op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic [TW-1:0] tag);
    fifo_entry_t e;
    e.op = op; e.a = a; e.b = b; e.tag = tag;
    return e;
  endfunction

  function automatic res_t ref_op(input fifo_entry_t e);
    res_t r;
    longint unsigned ua = e.a;
    longint unsigned ub = e.b;
    longint unsigned s;
    if (e.op == OP_ADD) begin
      s = ua + ub;
      r.res  = W'(s);
      r.flag = (s > 64'h0000_0000_FFFF_FFFF);
    end else begin
      r.res  = e.a - e.b;
      r.flag = (ua < ub);
    end
    r.tag = e.tag;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: drive at the falling edge, compare against the model, advance the model.
  task automatic step(input fifo_entry_t e, input logic v, input logic rdy);
    bit exp_rdy;
    bit load;
    in_valid  = v;
    in_op     = e.op;
    in_a      = e.a;
    in_b      = e.b;
    in_tag    = e.tag;
    out_ready = rdy;
    #1;
    exp_rdy = (pend_q.size() != D);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, hold_v);
    chk("occupancy", occupancy, pend_q.size());
    if (hold_v) begin
      chk("out_result", out_result, hold.res);
      chk("out_flag", out_flag, hold.flag);
      chk("out_tag", out_tag, hold.tag);
    end
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    if (out_valid && rdy) begin
      hs_cnt++;
      hs_tags.push_back(out_tag);
    end
    load = (pend_q.size() > 0) && (!hold_v || rdy);
    if (load) begin
      hold   = pend_q.pop_front();
      hold_v = 1'b1;
    end else if (hold_v && rdy) begin
      hold_v = 1'b0;
    end
    if (v && exp_rdy) pend_q.push_back(ref_op(e));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(mk(1'b0, '0, '0, '0), 1'b0, rdy);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pend_q.delete();
    hold_v = 1'b0;
  endtask

  // Single op into an empty pipe: invisible one cycle after accept, valid the next.
  task automatic run_one(input string name, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] tag,
                         input logic [W-1:0] exp_res, input logic exp_flag);
    step(mk(op, a, b, tag), 1'b1, 1'b1);
    chk({name, "_lat1_valid"}, out_valid, 1'b0);
    step(mk(1'b0, '0, '0, '0), 1'b0, 1'b1);
    chk({name, "_lat2_valid"}, out_valid, 1'b1);
    chk({name, "_result"}, out_result, exp_res);
    chk({name, "_flag"}, out_flag, exp_flag);
    chk({name, "_tag"}, out_tag, tag);
    idle(1, 1'b1);
  endtask

  logic [W-1:0]  r_res;
  logic          r_flag;
  logic [TW-1:0] r_tag;
  int            hs0;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    hold_v    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);

    run_one("sub_neg",   OP_SUB, 32'h0000_0005, 32'h0000_0007, 4'd3, 32'hFFFF_FFFE, 1'b1);
    run_one("sub_xhalf", OP_SUB, 32'h0001_0000, 32'h0000_0001, 4'd6, 32'h0000_FFFF, 1'b0);
    run_one("add_wrap",  OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 4'd9, 32'h0000_0000, 1'b1);
    run_one("add_plain", OP_ADD, 32'h1234_5678, 32'h1111_1111, 4'd1, 32'h2345_6789, 1'b0);
    run_one("sub_eq",    OP_SUB, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd2, 32'h0000_0000, 1'b0);

    // Backpressure: five ops fill the FIFO plus the output register.
    hs_tags.delete();
    for (int i = 0; i < 5; i++)
      step(mk(i[0], W'(32'h100 * i), W'(i), TW'(i)), 1'b1, 1'b0);
    chk("bp_occupancy", occupancy, 4);
    chk("bp_in_ready", in_ready, 1'b0);
    step(mk(1'b0, 32'h77, 32'h1, 4'd5), 1'b1, 1'b0);
    r_res  = out_result;
    r_flag = out_flag;
    r_tag  = out_tag;
    idle(3, 1'b0);
    chk("bp_stable_res", out_result, r_res);
    chk("bp_stable_flag", out_flag, r_flag);
    chk("bp_stable_tag", out_tag, r_tag);
    idle(7, 1'b1);
    chk("bp_count", hs_tags.size(), 5);
    for (int i = 0; i < 5 && i < hs_tags.size(); i++)
      chk("bp_tag_order", hs_tags[i], TW'(i));

    // Streaming at one op per cycle.
    idle(2, 1'b1);
    hs0     = hs_cnt;
    max_occ = 0;
    for (int i = 0; i < 16; i++)
      step(mk(1'($urandom), rand_operand(), rand_operand(), TW'(i)), 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("stream_count", hs_cnt - hs0, 16);
    chk("stream_max_occ", max_occ, 1);

    // Reset with work in flight: nothing stale may come out afterwards.
    for (int i = 0; i < 4; i++)
      step(mk(OP_ADD, W'(i), W'(i), TW'(i)), 1'b1, 1'b0);
    chk("pre_rst_occupancy", occupancy, 3);
    chk("pre_rst_out_valid", out_valid, 1'b1);
    do_reset();
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_occupancy", occupancy, 0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    hs0 = hs_cnt;
    idle(6, 1'b1);
    chk("mid_rst_no_stale", hs_cnt - hs0, 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 1500; i++)
      step(mk(1'($urandom), rand_operand(), rand_operand(), TW'($urandom)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    idle(8, 1'b1);
    chk("final_drained", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
